// File: rtl/padding_stream_controller.sv
// Walks the zero-padded (IMG_H+2*PAD) x (IMG_W+2*PAD) grid in raster order, reading interior pixels
// from the input RAM and steering the padding mux to zero on border positions.
module padding_stream_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int PAD        = 1,
   parameter int ADDR_WIDTH = 10,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  PADC_CLOCK_50,
   input  logic                  PADC_RESET_InLow,
   input  logic                  PADC_start,
   input  logic                  PADC_ready_in,
   output logic                  PADC_mem_rd_en,
   output logic [ADDR_WIDTH-1:0] PADC_mem_addr,
   output logic                  PADC_pad_sel,
   output logic                  PADC_valid,
   output logic [CNT_WIDTH-1:0]  PADC_row,
   output logic [CNT_WIDTH-1:0]  PADC_col,
   output logic                  PADC_busy,
   output logic                  PADC_done
);

   localparam int PW = IMG_W + 2*PAD;
   localparam int PH = IMG_H + 2*PAD;

   localparam logic [CNT_WIDTH-1:0] PW_LAST = CNT_WIDTH'(PW - 1);
   localparam logic [CNT_WIDTH-1:0] PH_LAST = CNT_WIDTH'(PH - 1);
   localparam logic [CNT_WIDTH-1:0] PAD_C   = CNT_WIDTH'(PAD);
   localparam logic [CNT_WIDTH-1:0] IMG_W_C = CNT_WIDTH'(IMG_W);
   localparam logic [CNT_WIDTH-1:0] IMG_H_C = CNT_WIDTH'(IMG_H);

   if (DATA_WIDTH < 1 || IMG_W < 1 || IMG_H < 1 || PAD < 0 || PAD > 3 ||
       (2**ADDR_WIDTH) < IMG_W*IMG_H || (2**CNT_WIDTH) <= PW || (2**CNT_WIDTH) <= PH) begin : g_bad_params
      $error("padding_stream_controller: inconsistent parameters");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  row_cnt;
   logic [CNT_WIDTH-1:0]  col_cnt;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [CNT_WIDTH-1:0]  row_off;
   logic [CNT_WIDTH-1:0]  col_off;
   logic                  pad;
   logic                  issue;
   logic                  accept;
   logic                  last_pos;

   // Positions left of / above the image wrap to large values after subtracting PAD, so a single
   // unsigned compare per axis covers both sides of the border.
   assign row_off  = row_cnt - PAD_C;
   assign col_off  = col_cnt - PAD_C;
   assign pad      = ~((row_off < IMG_H_C) & (col_off < IMG_W_C));

   assign issue    = (state == S_RUN) & (~PADC_valid | PADC_ready_in);
   assign accept   = PADC_valid & PADC_ready_in;
   assign last_pos = (row_cnt == PH_LAST) & (col_cnt == PW_LAST);

   assign PADC_mem_rd_en = issue & ~pad;
   assign PADC_mem_addr  = addr_cnt;
   assign PADC_busy      = (state == S_RUN) | (state == S_FLUSH);

   always_ff @(posedge PADC_CLOCK_50 or negedge PADC_RESET_InLow) begin
      if (!PADC_RESET_InLow) begin
         state        <= S_IDLE;
         row_cnt      <= '0;
         col_cnt      <= '0;
         addr_cnt     <= '0;
         PADC_valid   <= 1'b0;
         PADC_pad_sel <= 1'b0;
         PADC_row     <= '0;
         PADC_col     <= '0;
         PADC_done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (PADC_start) begin
                  state    <= S_RUN;
                  row_cnt  <= '0;
                  col_cnt  <= '0;
                  addr_cnt <= '0;
               end
            end
            S_RUN: begin
               if (issue) begin
                  if (last_pos) state <= S_FLUSH;
                  if (col_cnt == PW_LAST) begin
                     col_cnt <= '0;
                     row_cnt <= row_cnt + 1'b1;
                  end else begin
                     col_cnt <= col_cnt + 1'b1;
                  end
                  if (!pad) addr_cnt <= addr_cnt + 1'b1;
               end
            end
            S_FLUSH: begin
               if (accept) begin
                  state     <= S_DONE;
                  PADC_done <= 1'b1;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               PADC_done <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase

         // Output stage trails the issue by one cycle to line up with the RAM read data.
         if (issue) begin
            PADC_valid   <= 1'b1;
            PADC_pad_sel <= pad;
            PADC_row     <= row_cnt;
            PADC_col     <= col_cnt;
         end else if (accept) begin
            PADC_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_padding_stream_controller.sv
// Scoreboard bench for padding_stream_controller: three configurations share clock, reset and ready;
// one is active at a time and a negedge monitor checks every accepted beat against the expected queue.
module tb_padding_stream_controller;

   localparam int AW = 10;
   localparam int CW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          ready;
   logic [2:0]    start;
   logic [2:0]    rd_en, pad_sel, valid, busy, done;
   logic [AW-1:0] addr [3];
   logic [CW-1:0] row  [3];
   logic [CW-1:0] col  [3];
   logic [AW-1:0] ram_q [3];

   padding_stream_controller #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4), .PAD(1), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_a (
      .PADC_CLOCK_50(clk), .PADC_RESET_InLow(rst_n), .PADC_start(start[0]), .PADC_ready_in(ready),
      .PADC_mem_rd_en(rd_en[0]), .PADC_mem_addr(addr[0]), .PADC_pad_sel(pad_sel[0]), .PADC_valid(valid[0]),
      .PADC_row(row[0]), .PADC_col(col[0]), .PADC_busy(busy[0]), .PADC_done(done[0]));

   padding_stream_controller #(.DATA_WIDTH(8), .IMG_W(3), .IMG_H(2), .PAD(0), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_b (
      .PADC_CLOCK_50(clk), .PADC_RESET_InLow(rst_n), .PADC_start(start[1]), .PADC_ready_in(ready),
      .PADC_mem_rd_en(rd_en[1]), .PADC_mem_addr(addr[1]), .PADC_pad_sel(pad_sel[1]), .PADC_valid(valid[1]),
      .PADC_row(row[1]), .PADC_col(col[1]), .PADC_busy(busy[1]), .PADC_done(done[1]));

   padding_stream_controller #(.DATA_WIDTH(8), .IMG_W(28), .IMG_H(28), .PAD(2), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) u_c (
      .PADC_CLOCK_50(clk), .PADC_RESET_InLow(rst_n), .PADC_start(start[2]), .PADC_ready_in(ready),
      .PADC_mem_rd_en(rd_en[2]), .PADC_mem_addr(addr[2]), .PADC_pad_sel(pad_sel[2]), .PADC_valid(valid[2]),
      .PADC_row(row[2]), .PADC_col(col[2]), .PADC_busy(busy[2]), .PADC_done(done[2]));

   // RAM stand-in: the data word is the address it was read from, and it holds when rd_en is low.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         if (rd_en[i]) ram_q[i] <= addr[i];
   end

   typedef struct {
      logic pad;
      int   row;
      int   col;
      int   addr;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    sel = 0;
   int    beats = 0;
   int    rd_cnt = 0;
   int    done_cnt = 0;
   logic  rand_ready = 1'b0;
   logic  prev_stall = 1'b0;
   int    prev_row, prev_col, prev_pad;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic push_frame(input int w, input int h, input int p);
      int a = 0;
      for (int r = 0; r < h + 2*p; r++)
         for (int c = 0; c < w + 2*p; c++) begin
            beat_t b;
            b.pad  = (r < p) || (r >= p + h) || (c < p) || (c >= p + w);
            b.row  = r;
            b.col  = c;
            b.addr = b.pad ? -1 : a;
            if (!b.pad) a++;
            exp_q.push_back(b);
         end
   endtask

   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (rd_en[sel]) rd_cnt++;
         if (done[sel]) done_cnt++;
         if (prev_stall) begin
            chk("stall_hold_row", int'(row[sel]), prev_row);
            chk("stall_hold_col", int'(col[sel]), prev_col);
            chk("stall_hold_pad", int'(pad_sel[sel]), prev_pad);
            chk("stall_hold_valid", int'(valid[sel]), 1);
         end
         if (valid[sel] && !ready) chk("stall_rd_en", int'(rd_en[sel]), 0);
         if (valid[sel] && ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 1, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               beats++;
               chk("beat_pad_sel", int'(pad_sel[sel]), int'(e.pad));
               chk("beat_row", int'(row[sel]), e.row);
               chk("beat_col", int'(col[sel]), e.col);
               if (!e.pad) chk("beat_addr", int'(ram_q[sel]), e.addr);
            end
         end
         prev_stall = valid[sel] && !ready;
         prev_row   = int'(row[sel]);
         prev_col   = int'(col[sel]);
         prev_pad   = int'(pad_sel[sel]);
      end
   end

   task automatic pulse_start(input int idx);
      @(posedge clk);
      #1 start[idx] = 1'b1;
      @(posedge clk);
      #1 start[idx] = 1'b0;
   endtask

   task automatic run_frame(input int idx, input int w, input int h, input int p,
                            input bit lat_chk, input bit repulse);
      int k, rd0, d0, budget;
      sel    = idx;
      rd0    = rd_cnt;
      d0     = done_cnt;
      budget = 8 * (w + 2*p) * (h + 2*p) + 50;
      push_frame(w, h, p);
      pulse_start(idx);
      k = 0;
      while (k < budget) begin
         @(negedge clk);
         k++;
         if (repulse && k == 5) start[idx] = 1'b1;
         if (repulse && k == 6) start[idx] = 1'b0;
         if (done[idx]) break;
      end
      if (k >= budget) chk("done_timeout", k, 0);
      if (lat_chk) chk("done_latency", k, (w + 2*p) * (h + 2*p) + 2);
      if (repulse) begin
         start[idx] = 1'b1;
         @(posedge clk);
         #1 start[idx] = 1'b0;
         repeat (10) @(negedge clk);
         chk("no_restart_busy", int'(busy[idx]), 0);
      end else begin
         @(negedge clk);
      end
      chk("queue_empty", exp_q.size(), 0);
      chk("rd_en_count", rd_cnt - rd0, w * h);
      chk("done_count", done_cnt - d0, 1);
      chk("idle_valid", int'(valid[idx]), 0);
   endtask

   task automatic chk_reset_outputs(input int idx);
      chk("rst_valid", int'(valid[idx]), 0);
      chk("rst_rd_en", int'(rd_en[idx]), 0);
      chk("rst_addr", int'(addr[idx]), 0);
      chk("rst_pad_sel", int'(pad_sel[idx]), 0);
      chk("rst_row", int'(row[idx]), 0);
      chk("rst_col", int'(col[idx]), 0);
      chk("rst_busy", int'(busy[idx]), 0);
      chk("rst_done", int'(done[idx]), 0);
   endtask

   initial begin
      int k, d0;
      start = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk_reset_outputs(i);
      @(negedge clk);
      rst_n = 1'b1;

      // 4x4, PAD=1, ready high: 36 beats, done 38 cycles after the start sample
      run_frame(0, 4, 4, 1, 1'b1, 1'b0);

      // same frame with ready toggling
      rand_ready = 1'b1;
      run_frame(0, 4, 4, 1, 1'b0, 1'b0);
      rand_ready = 1'b0;

      // start re-pulsed during RUN and during DONE
      run_frame(0, 4, 4, 1, 1'b0, 1'b1);

      // abort at beat 10 with reset, then a clean frame
      sel   = 0;
      d0    = done_cnt;
      beats = 0;
      push_frame(4, 4, 1);
      pulse_start(0);
      k = 0;
      while (beats < 10 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reached_beat10", int'(beats >= 10), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs(0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk_reset_outputs(0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      run_frame(0, 4, 4, 1, 1'b1, 1'b0);

      // PAD=0, 3x2
      run_frame(1, 3, 2, 0, 1'b1, 1'b0);

      // 28x28, PAD=2
      run_frame(2, 28, 28, 2, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
